// File: rtl/time_display_pkg.sv
// Shared constants for time_display: field widths, blink field codes, alarm states, glyphs.
// Alarm state set depends on TIME_DISPLAY_ALARM_SWEEP_EN.
package time_display_pkg;

   localparam int unsigned HOUR_W = 5;
   localparam int unsigned MIN_W  = 6;
   localparam int unsigned SEC_W  = 6;
   localparam int unsigned TIME_W = HOUR_W + MIN_W + SEC_W;

   typedef enum logic [1:0] {
      BLINK_NONE    = 2'd0,
      BLINK_HOURS   = 2'd1,
      BLINK_MINUTES = 2'd2,
      BLINK_SECONDS = 2'd3
   } blink_field_t;

`ifdef TIME_DISPLAY_ALARM_SWEEP_EN
   typedef enum logic [1:0] {IDLE, SWEEP_UP, SWEEP_DOWN} alarm_state_t;
`else
   typedef enum logic [0:0] {IDLE, FLASH} alarm_state_t;
`endif

   // Active-high segment sets, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_DASH  = 7'h40;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   function automatic logic [6:0] glyph_of(input logic [3:0] v);
      case (v)
         4'd0:    return GLYPH_0;
         4'd1:    return GLYPH_1;
         4'd2:    return GLYPH_2;
         4'd3:    return GLYPH_3;
         4'd4:    return GLYPH_4;
         4'd5:    return GLYPH_5;
         4'd6:    return GLYPH_6;
         4'd7:    return GLYPH_7;
         4'd8:    return GLYPH_8;
         4'd9:    return GLYPH_9;
         default: return GLYPH_BLANK;
      endcase
   endfunction

   function automatic logic [3:0] bcd_digit(input logic [5:0] v, input logic tens);
      logic [5:0] q;
      q = tens ? (v / 6'd10) : (v % 6'd10);
      return q[3:0];
   endfunction

endpackage

// File: rtl/time_display_tick.sv
// tick_gen: divide-by-DIV counter emitting a one-cycle tick, with synchronous clear.
module tick_gen #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/time_display.sv
// Multiplexed 7-segment clock display with blink and alarm LED pattern.
// TIME_DISPLAY_ALARM_SWEEP_EN selects the bouncing LED sweep; otherwise LEDs flash with blink.
module time_display
   import time_display_pkg::*;
#(
   parameter int unsigned N_DIGITS  = 4,
   parameter int unsigned N_LEDS    = 8,
   parameter int unsigned SCAN_DIV  = 100000,
   parameter int unsigned BLINK_DIV = 25000000,
   parameter int unsigned STEP_DIV  = 5000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                mod12_24,
   input  logic                alarm,
   input  logic [1:0]          blink_field,
   input  logic [16:0]         disp_time,
   output logic [N_DIGITS-1:0] an,
   output logic [7:0]          seg,
   output logic [N_LEDS-1:0]   leds
);

   localparam logic [N_DIGITS-1:0] AN_ONE  = {{(N_DIGITS-1){1'b0}}, 1'b1};
   localparam logic [N_LEDS-1:0]   LED_LSB = {{(N_LEDS-1){1'b0}}, 1'b1};

   logic              scan_tick, blink_tick, wrap, blink_on;
   logic [2:0]        digit_idx;
   logic [HOUR_W-1:0] snap_hr, hr_disp;
   logic [MIN_W-1:0]  snap_min;
   logic [SEC_W-1:0]  snap_sec;
   logic              snap_12h;
   blink_field_t      snap_bf, fld;
   logic              hr_bad, min_bad, sec_bad, pm;
   logic [5:0]        fval;
   logic              fbad, is_tens, dp_on, blanked;
   logic [3:0]        digit;
   logic [6:0]        glyph;
   alarm_state_t      state, next_state;
   logic [N_LEDS-1:0] next_leds, idle_leds;

   tick_gen #(.DIV(SCAN_DIV))  u_scan  (.clk(clk), .reset(reset), .clear(1'b0), .tick(scan_tick));
   tick_gen #(.DIV(BLINK_DIV)) u_blink (.clk(clk), .reset(reset), .clear(1'b0), .tick(blink_tick));

   assign wrap = scan_tick && (digit_idx == 3'(N_DIGITS - 1));

   // Inputs are captured only at frame start so a frame never mixes two times.
   always_ff @(posedge clk) begin
      if (reset) begin
         digit_idx <= '0;
         blink_on  <= 1'b1;
         snap_hr   <= '0;
         snap_min  <= '0;
         snap_sec  <= '0;
         snap_12h  <= 1'b0;
         snap_bf   <= BLINK_NONE;
      end else begin
         if (scan_tick)
            digit_idx <= wrap ? 3'd0 : digit_idx + 3'd1;
         if (wrap) begin
            snap_hr  <= disp_time[16:12];
            snap_min <= disp_time[11:6];
            snap_sec <= disp_time[5:0];
            snap_12h <= mod12_24;
            snap_bf  <= blink_field_t'(blink_field);
         end
         if (blink_tick)
            blink_on <= ~blink_on;
      end
   end

   always_comb begin
      hr_bad  = (snap_hr > 5'd23);
      min_bad = (snap_min > 6'd59);
      sec_bad = (snap_sec > 6'd59);
      pm      = snap_12h && !hr_bad && (snap_hr >= 5'd12);
      hr_disp = snap_hr;
      if (snap_12h) begin
         if (snap_hr == '0)
            hr_disp = 5'd12;
         else if (snap_hr > 5'd12)
            hr_disp = snap_hr - 5'd12;
      end
   end

   always_comb begin
      fld = BLINK_MINUTES;
      if (N_DIGITS == 6) begin
         case (digit_idx[2:1])
            2'd0:    fld = BLINK_SECONDS;
            2'd1:    fld = BLINK_MINUTES;
            default: fld = BLINK_HOURS;
         endcase
      end else begin
         fld = digit_idx[1] ? BLINK_HOURS : BLINK_MINUTES;
      end
      is_tens = digit_idx[0];
      case (fld)
         BLINK_HOURS:   begin fval = {1'b0, hr_disp}; fbad = hr_bad;  end
         BLINK_MINUTES: begin fval = snap_min;        fbad = min_bad; end
         default:       begin fval = snap_sec;        fbad = sec_bad; end
      endcase
      digit = bcd_digit(fval, is_tens);
      if (fbad)
         glyph = GLYPH_DASH;
      else if (is_tens && (fld == BLINK_HOURS) && snap_12h && (digit == '0))
         glyph = GLYPH_BLANK;
      else
         glyph = glyph_of(digit);
      // Separator sits on the ones digit of every field except the rightmost.
      dp_on   = !digit_idx[0] && (digit_idx != '0);
      blanked = !blink_on && (snap_bf == fld);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         an  <= '1;
         seg <= '1;
      end else begin
         an  <= blanked ? '1 : ~(AN_ONE << digit_idx);
         seg <= ~{dp_on, glyph};
      end
   end

   assign idle_leds = {{(N_LEDS-1){1'b0}}, pm};

`ifdef TIME_DISPLAY_ALARM_SWEEP_EN
   logic step_tick, step_clear;

   assign step_clear = (state == IDLE) || !alarm;

   tick_gen #(.DIV(STEP_DIV)) u_step (.clk(clk), .reset(reset), .clear(step_clear), .tick(step_tick));

   always_comb begin
      next_state = state;
      next_leds  = leds;
      if (!alarm) begin
         next_state = IDLE;
         next_leds  = idle_leds;
      end else begin
         case (state)
            IDLE: begin
               next_state = SWEEP_UP;
               next_leds  = LED_LSB;
            end
            SWEEP_UP: if (step_tick) begin
               next_leds = leds << 1;
               if (leds[N_LEDS-2]) next_state = SWEEP_DOWN;
            end
            SWEEP_DOWN: if (step_tick) begin
               next_leds = leds >> 1;
               if (leds[1]) next_state = SWEEP_UP;
            end
            default: begin
               next_state = IDLE;
               next_leds  = idle_leds;
            end
         endcase
      end
   end
`else
   always_comb begin
      next_state = state;
      next_leds  = leds;
      if (!alarm) begin
         next_state = IDLE;
         next_leds  = idle_leds;
      end else begin
         next_state = FLASH;
         next_leds  = blink_on ? '1 : '0;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         leds  <= '0;
      end else begin
         state <= next_state;
         leds  <= next_leds;
      end
   end

endmodule
